// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: instruction fetch stage and IF/ID pipeline register.
// Holds the PC, drives the instruction-memory address and latches the
// returned word for the decoder. Handles start/halt sequencing, branch
// redirect with a one-cycle flush, and decode stalls.
// Optional feature macro: IFETCH_DYN_COUNT_EN enables the dynamic
// instruction counter. When it is undefined, dyn_count_o is tied to zero.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | out of reset; PC and IF/ID hold, waiting for start_i
// RUN   | fetching; advance / stall / redirect / halt handled each edge
// HALT  | decoder saw halt; fetch frozen until start_i
module instr_fetch_stage #(
    parameter int unsigned          PC_W       = 8,
    parameter int unsigned          INSTR_W    = 9,
    parameter logic [PC_W-1:0]      START_ADDR = '0,
    parameter logic [INSTR_W-1:0]   BUBBLE     = 9'h1B0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                halt_i,
    input  logic                stall_i,
    input  logic                branch_taken_i,
    input  logic [PC_W-1:0]     branch_target_i,
    output logic [PC_W-1:0]     imem_addr_o,
    input  logic [INSTR_W-1:0]  imem_rdata_i,
    output logic [INSTR_W-1:0]  instr_o,
    output logic [PC_W-1:0]     instr_pc_o,
    output logic                instr_valid_o,
    output logic                running_o,
    output logic [15:0]         dyn_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t              state;
    logic [PC_W-1:0]     pc;
    logic                start_ok;
    logic                advance;

    // start_i only matters outside RUN; advance is the one case that loads a real instruction
    assign start_ok    = start_i && (state != ST_RUN);
    assign advance     = (state == ST_RUN) && !halt_i && !branch_taken_i && !stall_i;
    assign imem_addr_o = pc;

    // Sequencing FSM with PC and IF/ID register; priority in RUN is halt > branch > stall > advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            pc            <= START_ADDR;
            instr_o       <= BUBBLE;
            instr_pc_o    <= '0;
            instr_valid_o <= 1'b0;
            running_o     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (start_ok) begin
                        state         <= ST_RUN;
                        running_o     <= 1'b1;
                        pc            <= START_ADDR;
                        instr_o       <= BUBBLE;
                        instr_valid_o <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (halt_i) begin
                        // PC holds so the halting point stays visible on imem_addr_o
                        state         <= ST_HALT;
                        running_o     <= 1'b0;
                        instr_o       <= BUBBLE;
                        instr_valid_o <= 1'b0;
                    end else if (branch_taken_i) begin
                        // Redirect wins over stall: the wrong-path word must never reach decode
                        pc            <= branch_target_i;
                        instr_o       <= BUBBLE;
                        instr_valid_o <= 1'b0;
                    end else if (advance) begin
                        instr_o       <= imem_rdata_i;
                        instr_pc_o    <= pc;
                        instr_valid_o <= 1'b1;
                        pc            <= pc + PC_W'(1);
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    running_o     <= 1'b0;
                    instr_o       <= BUBBLE;
                    instr_valid_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef IFETCH_DYN_COUNT_EN
    logic [15:0] dyn_count;

    // Count valid IF/ID loads, saturating; a fresh start begins a new count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dyn_count <= 16'h0000;
        end else if (start_ok) begin
            dyn_count <= 16'h0000;
        end else if (advance && (dyn_count != 16'hFFFF)) begin
            dyn_count <= dyn_count + 16'h0001;
        end
    end

    assign dyn_count_o = dyn_count;
`else
    assign dyn_count_o = 16'h0000;
`endif

endmodule
